// File: rtl/divisor_pkg.sv
// divisor_pkg: shared definitions for the divisor_param restoring divider.
//   state_t     : FSM state encoding (IDLE, RUN, FIN)
//   ctr_w()     : iteration counter width for a given operand width
//   dz_quotient : all-ones quotient pattern returned on divide by zero
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Widest operand the dz_quotient generator supports.
  localparam int unsigned MAX_WIDTH = 64;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int unsigned ctr_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] dz_quotient(input int unsigned width);
    logic [MAX_WIDTH-1:0] q;
    q = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) q[i] = 1'b1;
    end
    return q;
  endfunction

endpackage

// File: rtl/divisor_step.sv
// divisor_step: one combinational restoring-division iteration.
//   acc_in  : {A, DV} partial remainder and dividend/quotient shift register
//   dr      : divisor
//   acc_out : {A, DV} after shift-left and conditional subtract; the new
//             quotient bit enters DV[0]
module divisor_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   dr,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] trial;
  logic             fits;

  always_comb begin
    // Shifted partial remainder keeps the bit pushed out of A's MSB.
    a_sh  = acc_in[2*WIDTH-1:WIDTH-1];
    fits  = (a_sh >= {1'b0, dr});
    // When it fits the difference is below dr, so WIDTH bits are enough.
    trial = WIDTH'(a_sh - {1'b0, dr});
    if (fits) begin
      acc_out = {trial, acc_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = {a_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divisor_param.sv
// divisor_param: parametrised restoring divider, one iteration per clock.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   init           : start request, accepted only in IDLE
//   portA, portB   : dividend / divisor, latched on accept
//   D, M           : quotient / remainder, hold the last result
//   done           : one-cycle pulse when D/M update
//   busy           : high from accept through the done cycle
//   div_zero       : set with done for a zero divisor, cleared on next accept
// Optional macro DIVISOR_SIGNED_EN: two's-complement operands, magnitude
// division with sign fix-up applied in FIN.
module divisor_param
  import divisor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] M,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  localparam int unsigned            CTR_W  = ctr_w(WIDTH);
  localparam logic [MAX_WIDTH-1:0]   DZ_ALL = dz_quotient(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a_q, dv_q, dr_q;
  logic [CTR_W-1:0]   ct_q;
  logic               dz_q;
  logic [WIDTH-1:0]   d_q, m_q;
  logic               done_q, busy_q, div_zero_q;
  logic [2*WIDTH-1:0] acc_nxt;

  logic               accept, div0, fin_now;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   d_fin, m_fin, dz_rem;

  divisor_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  ({a_q, dv_q}),
    .dr      (dr_q),
    .acc_out (acc_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init) state_d = div0 ? FIN : RUN;
      RUN:     if (ct_q == CTR_W'(1)) state_d = FIN;
      FIN:     if (ct_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    accept  = (state_q == IDLE) && init;
    div0    = (portB == '0);
    fin_now = (state_q == FIN) && (ct_q == '0);
  end

`ifdef DIVISOR_SIGNED_EN
  logic [WIDTH-1:0] a_raw_q;
  logic             neg_q_q, neg_r_q;

  always_comb begin
    a_mag  = portA[WIDTH-1] ? WIDTH'('0 - portA) : portA;
    b_mag  = portB[WIDTH-1] ? WIDTH'('0 - portB) : portB;
    d_fin  = neg_q_q ? WIDTH'('0 - dv_q) : dv_q;
    m_fin  = neg_r_q ? WIDTH'('0 - a_q)  : a_q;
    dz_rem = a_raw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_raw_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      a_raw_q <= portA;
      neg_q_q <= portA[WIDTH-1] ^ portB[WIDTH-1];
      neg_r_q <= portA[WIDTH-1];
    end
  end
`else
  always_comb begin
    a_mag  = portA;
    b_mag  = portB;
    d_fin  = dv_q;
    m_fin  = a_q;
    // RUN is skipped for a zero divisor, so DV still holds the dividend.
    dz_rem = dv_q;
  end
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      dv_q       <= '0;
      dr_q       <= '0;
      ct_q       <= '0;
      dz_q       <= 1'b0;
      d_q        <= '0;
      m_q        <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= '0;
            dv_q       <= a_mag;
            dr_q       <= b_mag;
            // A zero divisor waits one extra edge in FIN so its done pulse
            // lands two edges after accept.
            ct_q       <= div0 ? CTR_W'(1) : CTR_W'(WIDTH);
            dz_q       <= div0;
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          {a_q, dv_q} <= acc_nxt;
          ct_q        <= ct_q - CTR_W'(1);
        end
        FIN: begin
          if (!fin_now) begin
            ct_q <= ct_q - CTR_W'(1);
          end else begin
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
            if (dz_q) begin
              d_q <= DZ_ALL[WIDTH-1:0];
              m_q <= dz_rem;
            end else begin
              d_q <= d_fin;
              m_q <= m_fin;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign D        = d_q;
  assign M        = m_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign div_zero = div_zero_q;

endmodule
